combo_lock_ctrl: RTL and testbench

Parametrised keypad combination-lock controller. Takes debounced, single-cycle key strobes from the keypad front end in the divided-clock domain, and checks a CODE_LEN-digit entry against a code register. The code register is reprogrammable while the lock is open. Consecutive failures are counted, and the lock enters a timed lockout with an alarm output after MAX_FAIL failures. The status outputs drive the panel LEDs.

---
 rtl/combo_lock_ctrl.sv | 137 +++++++++++++
 tb/tb_combo_lock_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: keypad combination lock with lockout and reprogrammable code; `COMBO_LOCK_TIMEOUT_EN adds an inactivity timeout
module combo_lock_ctrl #(
  parameter int CODE_LEN = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = {4'd0, 4'd8, 4'd2, 4'd5},
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_vld,
  input  logic [3:0]                      key_val,
  input  logic                            key_clr,
  input  logic                            prog_req,
  input  logic                            relock,
  output logic                            unlocked,
  output logic                            alarm,
  output logic [2:0]                      state,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);
  localparam int DW = $clog2(CODE_LEN+1);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int LW = $clog2(LOCKOUT_CYC);
  localparam int EW = 4*CODE_LEN;
  localparam logic [DW-1:0] DLAST = DW'(CODE_LEN-1);
  localparam logic [FW-1:0] FLAST = FW'(MAX_FAIL-1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LINIT = LW'(LOCKOUT_CYC-1);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, OPEN = 3'd2, PROG = 3'd3, LOCKOUT = 3'd4} state_e;
  if (CODE_LEN < 2 || MAX_FAIL < 1 || LOCKOUT_CYC < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("combo_lock_ctrl: parameter out of range");
  end
  state_e state_q, state_d;
  logic [EW-1:0] entry_q, entry_d, code_q, code_d, shifted;
  logic [DW-1:0] digit_q, digit_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lock_q, lock_d;
  logic unlocked_q, alarm_q, dig, tmo_hit;
  assign dig = key_vld && key_val < 4'd10;
  assign shifted = {entry_q[EW-5:0], key_val};
`ifdef COMBO_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC+1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC-1);
  logic [TW-1:0] tmo_q;
  logic busy;
  assign busy = state_q == ENTRY || state_q == PROG;
  assign tmo_hit = busy && tmo_q == TLAST;
  // restarts on every accepted key and whenever the state changes
  always_ff @(posedge clk) begin
    if (!reset) tmo_q <= '0;
    else tmo_q <= (busy && state_d == state_q && !dig) ? tmo_q + 1'b1 : '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    code_d = code_q;
    digit_d = digit_q;
    fail_d = fail_q;
    lock_d = lock_q;
    case (state_q)
      IDLE: if (dig) begin
        entry_d = shifted;
        digit_d = DW'(1);
        state_d = ENTRY;
      end
      ENTRY: if (key_clr || tmo_hit) begin
        digit_d = '0;
        state_d = IDLE;
      end else if (dig) begin
        entry_d = shifted;
        digit_d = digit_q == DLAST ? '0 : digit_q + 1'b1;
        if (digit_q == DLAST) begin
          if (shifted == code_q) begin
            fail_d = '0;
            state_d = OPEN;
          end else if (fail_q == FLAST) begin
            fail_d = FMAX;
            lock_d = LINIT;
            state_d = LOCKOUT;
          end else begin
            fail_d = fail_q + 1'b1;
            state_d = IDLE;
          end
        end
      end
      OPEN: if (relock) state_d = IDLE;
        else if (prog_req) begin
          digit_d = '0;
          state_d = PROG;
        end
      PROG: if (relock || key_clr || tmo_hit) begin
        digit_d = '0;
        state_d = relock ? IDLE : OPEN;
      end else if (dig) begin
        entry_d = shifted;
        digit_d = digit_q == DLAST ? '0 : digit_q + 1'b1;
        code_d = digit_q == DLAST ? shifted : code_q;
        state_d = digit_q == DLAST ? OPEN : PROG;
      end
      LOCKOUT: if (lock_q == '0) begin
        fail_d = '0;
        state_d = IDLE;
      end else lock_d = lock_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      entry_q <= '0;
      code_q <= DEFAULT_CODE;
      digit_q <= '0;
      fail_q <= '0;
      lock_q <= '0;
      unlocked_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      code_q <= code_d;
      digit_q <= digit_d;
      fail_q <= fail_d;
      lock_q <= lock_d;
      unlocked_q <= state_d == OPEN || state_d == PROG;
      alarm_q <= state_d == LOCKOUT;
    end
  end
  assign state = state_q;
  assign unlocked = unlocked_q;
  assign alarm = alarm_q;
  assign digit_cnt = digit_q;
  assign fail_cnt = fail_q;
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed keypad sequences checked every cycle against a decimal-arithmetic model of the lock
module tb_combo_lock_ctrl;
  localparam int MAXF = 3;
  localparam int LOCK = 1000;
  localparam int TMO = 500;
  localparam int DEF = 825;
  logic clk = 1'b0, reset = 1'b0, key_vld = 1'b0, key_clr = 1'b0, prog_req = 1'b0, relock = 1'b0;
  logic [3:0] key_val = 4'd0;
  logic unlocked, alarm;
  logic [2:0] state;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int m_st = 0, m_fail = 0, m_n = 0, m_ent = 0, m_code = DEF, m_lock = 0, m_idle = 0;
  combo_lock_ctrl #(.CODE_LEN(4), .DEFAULT_CODE(16'h0825), .MAX_FAIL(MAXF), .LOCKOUT_CYC(LOCK), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .key_vld(key_vld), .key_val(key_val), .key_clr(key_clr),
    .prog_req(prog_req), .relock(relock), .unlocked(unlocked), .alarm(alarm), .state(state),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  // code and entry are held as decimal numbers; states use the documented output encoding
  always @(posedge clk) begin : model
    bit d, tmo;
    d = key_vld && key_val < 4'd10;
    tmo = 1'b0;
    if (!reset) begin
      m_st = 0; m_fail = 0; m_n = 0; m_ent = 0; m_code = DEF; m_lock = 0; m_idle = 0;
    end else begin
`ifdef COMBO_LOCK_TIMEOUT_EN
      if (m_st == 1 || m_st == 3) begin
        m_idle++;
        tmo = m_idle == TMO;
      end
`endif
      case (m_st)
        0: if (d) begin m_ent = int'(key_val); m_n = 1; m_st = 1; end
        1: if (key_clr || tmo) begin m_n = 0; m_st = 0; end
          else if (d) begin
            m_ent = m_ent * 10 + int'(key_val); m_n++; m_idle = 0;
            if (m_n == 4) begin
              m_n = 0;
              if (m_ent == m_code) begin m_st = 2; m_fail = 0; end
              else begin
                m_fail++;
                if (m_fail >= MAXF) begin m_st = 4; m_lock = LOCK; end else m_st = 0;
              end
            end
          end
        2: if (relock) m_st = 0; else if (prog_req) begin m_st = 3; m_n = 0; m_ent = 0; m_idle = 0; end
        3: if (relock) begin m_st = 0; m_n = 0; end
          else if (key_clr || tmo) begin m_st = 2; m_n = 0; end
          else if (d) begin
            m_ent = m_ent * 10 + int'(key_val); m_n++; m_idle = 0;
            if (m_n == 4) begin m_code = m_ent; m_st = 2; m_n = 0; end
          end
        default: begin m_lock--; if (m_lock == 0) begin m_st = 0; m_fail = 0; end end
      endcase
      if (m_st != 1 && m_st != 3) m_idle = 0;
    end
  end
  always @(negedge clk) if (chk_en) begin
    cmp("state", 32'(state), 32'(m_st));
    cmp("unlocked", 32'(unlocked), 32'(m_st == 2 || m_st == 3));
    cmp("alarm", 32'(alarm), 32'(m_st == 4));
    cmp("digit_cnt", 32'(digit_cnt), 32'(m_n));
    cmp("fail_cnt", 32'(fail_cnt), 32'(m_fail));
  end
  task automatic press(input int v);
    key_vld = 1'b1; key_val = 4'(v);
    @(negedge clk);
    key_vld = 1'b0;
  endtask
  task automatic code4(input int a, input int b, input int c, input int e);
    press(a); press(b); press(c); press(e);
  endtask
  task automatic pulse(input bit clr, input bit prg, input bit rel);
    key_clr = clr; prog_req = prg; relock = rel;
    @(negedge clk);
    key_clr = 1'b0; prog_req = 1'b0; relock = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    idle(3);
    chk_en = 1'b1;
    cmp("rst_state", 32'(state), 0);
    cmp("rst_fail", 32'(fail_cnt), 0);
    cmp("rst_unlocked", 32'(unlocked), 0);
    reset = 1'b1;
    idle(1);
    code4(0, 8, 2, 5);
    cmp("open_state", 32'(state), 2);
    cmp("open_unlocked", 32'(unlocked), 1);
    key_vld = 1'b1; key_val = 4'd0;
    pulse(0, 0, 1);
    key_vld = 1'b0;
    cmp("relock_key_ignored_state", 32'(state), 0);
    cmp("relock_key_ignored_digits", 32'(digit_cnt), 0);
    code4(1, 2, 3, 4);
    cmp("fail1", 32'(fail_cnt), 1);
    code4(1, 2, 3, 4);
    cmp("fail2", 32'(fail_cnt), 2);
    code4(1, 2, 3, 4);
    cmp("lockout_state", 32'(state), 4);
    cmp("lockout_alarm", 32'(alarm), 1);
    code4(0, 8, 2, 5);
    idle(LOCK - 5);
    cmp("lockout_last_cycle", 32'(state), 4);
    idle(1);
    cmp("lockout_exit_state", 32'(state), 0);
    cmp("lockout_exit_fail", 32'(fail_cnt), 0);
    cmp("lockout_exit_alarm", 32'(alarm), 0);
    code4(0, 8, 2, 5);
    pulse(0, 1, 0);
    cmp("prog_state", 32'(state), 3);
    code4(9, 9, 1, 3);
    cmp("prog_done", 32'(state), 2);
    pulse(0, 0, 1);
    code4(0, 8, 2, 5);
    cmp("old_code_fails", 32'(fail_cnt), 1);
    code4(9, 9, 1, 3);
    cmp("new_code_opens", 32'(unlocked), 1);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    code4(0, 8, 2, 5);
    cmp("reset_restores_code", 32'(unlocked), 1);
    pulse(0, 0, 1);
    code4(1, 1, 1, 1);
    press(0); press(8);
    pulse(1, 0, 0);
    cmp("clr_state", 32'(state), 0);
    cmp("clr_digits", 32'(digit_cnt), 0);
    cmp("clr_fail_kept", 32'(fail_cnt), 1);
    press(12);
    press(0); press(12);
    cmp("bad_key_entry", 32'(digit_cnt), 1);
    press(8); press(2); press(5);
    press(12);
    pulse(0, 1, 0);
    press(12);
    cmp("bad_key_prog", 32'(digit_cnt), 0);
    press(4); press(4);
    key_vld = 1'b1; key_val = 4'd7;
    pulse(0, 0, 1);
    key_vld = 1'b0;
    cmp("prog_relock_state", 32'(state), 0);
    code4(0, 8, 2, 5);
    cmp("partial_not_committed", 32'(state), 2);
    pulse(0, 1, 1);
    cmp("relock_over_prog", 32'(state), 0);
    pulse(1, 1, 1);
    cmp("idle_ignores_ctrl", 32'(state), 0);
    press(0);
`ifdef COMBO_LOCK_TIMEOUT_EN
    idle(TMO - 1);
    cmp("before_timeout", 32'(state), 1);
    idle(1);
    cmp("timeout_state", 32'(state), 0);
    cmp("timeout_fail", 32'(fail_cnt), 0);
`else
    idle(10000);
    cmp("no_timeout_state", 32'(state), 1);
    cmp("no_timeout_digits", 32'(digit_cnt), 1);
`endif
    idle(2);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
